// File: rtl/mul_mod_if.sv
// Start/ready handshake and operand/result bus of the iterative modular multiplier.
interface mul_mod_if #(
  parameter int W = 31
);
  logic         opselect;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [W-1:0] _mul;
  logic         _rdy;

  modport master (
    output opselect, a, b,
    input  _mul, _rdy
  );

  modport slave (
    input  opselect, a, b,
    output _mul, _rdy
  );
endinterface

// File: rtl/mul_mod.sv
// a*b mod (2^W-1), MSB-first shift-and-add, one multiplier bit per clock.
// Latency 32 cycles from accept to result; _rdy low while busy, starts ignored.
module mul_mod #(
  parameter int W = 31
) (
  input logic      clk,
  input logic      rst_n,
  mul_mod_if.slave bus
);
  localparam int           IW = $clog2(W);
  localparam logic [W-1:0] P  = {W{1'b1}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    NORM = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [W-1:0]  a_q, b_q, acc_q, mul_q;
  logic [W-1:0]  dbl, acc_step;
  logic [W:0]    sum;
  logic [IW-1:0] i_q;
  logic          start, last_bit;

  assign start    = (state_q == IDLE) && bus.opselect;
  assign last_bit = (i_q == '0);

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.opselect) state_d = RUN;
      RUN:     if (last_bit) state_d = NORM;
      NORM:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Doubling mod 2^W-1 is a rotate; the carry out of the add wraps back in.
  // acc stays within [0, P], so the wrapped add never overflows W bits.
  always_comb begin
    dbl      = {acc_q[W-2:0], acc_q[W-1]};
    sum      = {1'b0, dbl} + (b_q[i_q] ? {1'b0, a_q} : '0);
    acc_step = sum[W-1:0] + {{(W-1){1'b0}}, sum[W]};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_q   <= '0;
      b_q   <= '0;
      acc_q <= '0;
      i_q   <= '0;
      mul_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            a_q   <= bus.a;
            b_q   <= bus.b;
            acc_q <= '0;
            i_q   <= IW'(W - 1);
          end
        end
        RUN: begin
          acc_q <= acc_step;
          i_q   <= i_q - 1'b1;
        end
        NORM:    mul_q <= (acc_q == P) ? '0 : acc_q;
        default: ;
      endcase
    end
  end

  always_comb begin
    bus._rdy = (state_q == IDLE);
    bus._mul = mul_q;
  end
endmodule

// File: doc/mul_mod.md
# mul_mod

Iterative modular multiplier over the Mersenne prime field p = 2^W − 1 (W = 31, p = 0x7FFFFFFF). It computes _mul = a·b mod p using MSB-first shift-and-add with end-around-carry reduction, one multiplier bit per clock. It is the forward counterpart of the ALU's division path (multiply by modular inverse) and produces operands that the divider consumes. It uses the same opselect/_rdy start–ready handshake as the other iterative ALU units.

## Interface
- W, 31, field exponent; p = 2^W − 1. Only Mersenne exponents are supported; verification is required at 31 only.
- clk  in  1  rising-edge clock; the only clock.
- rst_n  in  1  synchronous, active-low reset.
- opselect  in  1  start request; sampled on the rising edge of clk.
- a  in  W  multiplicand, unsigned field element.
- b  in  W  multiplier, unsigned field element.
- _mul  out  W  result, canonical in [0, p−1]; holds its value until the next completion or reset.
- _rdy  out  1  1 = idle and able to accept a start; 0 = busy.

## Operation
- States:
  - IDLE (_rdy = 1).
  - RUN (31 bit steps, counter i = W−1 down to 0).
  - NORM (final normalization).
- Start: at a rising edge with rst_n = 1, state IDLE and opselect = 1:
  - latch A ← a and B ← b;
  - set acc ← 0 and i ← W−1;
  - go to RUN, with _rdy = 0 after that edge.
- In IDLE with opselect = 0, nothing changes.
- While not in IDLE, opselect, a and b are ignored. Operand changes after acceptance do not affect the result.
- Operands equal to p (0x7FFFFFFF) are congruent to 0 and need no special handling; the arithmetic below produces 0.
- RUN step, one per edge:
  - d = rotl1(acc). Doubling mod p is a 1-bit left rotate within W bits, because 2^W ≡ 1.
  - s = d + (B[i] ? A : 0), computed at W+1 bits.
  - acc ← s[W−1:0] + s[W], the end-around carry; it cannot overflow W bits.
  - i ← i − 1. After the step with i = 0, go to NORM.
- Invariant: acc is always in [0, p]. The value p is a legal non-canonical representation of 0 during RUN.
- NORM:
  - _mul ← (acc == p) ? 0 : acc;
  - go to IDLE, with _rdy = 1 after this edge.
- Reset (rst_n = 0 at an edge) overrides everything, including a simultaneous opselect:
  - state ← IDLE, _rdy ← 1, _mul ← 0;
  - acc, A, B and i are cleared.
  - An operation in progress is aborted, and no partial result appears on _mul.

## Timing
- Reset values: _rdy = 1, _mul = 0.
- The accept edge is E0. RUN occupies edges E1…E31. NORM is at edge E32.
- _mul updates and _rdy rises together after E32, giving a fixed latency of 32 cycles.
- _rdy is low from after E0 through E32.
- The earliest next start is E33, when opselect is sampled with _rdy = 1.
- Issue rate is 33 cycles per operation.
- _mul is stable for the whole busy period and shows the previous result.
- A consumer must sample _mul only when _rdy = 1.
- opselect held high continuously gives back-to-back operations, each accepted on the first edge after _rdy rises.

## Test plan
- After reset: a = 3, b = 5, one-cycle opselect pulse → _rdy low for E1–E32; _mul = 15 and _rdy = 1 after E32.
- a = 0x7FFFFFFE, b = 0x7FFFFFFE, i.e. (−1)·(−1) → _mul = 1. Then a = 0x40000000, b = 2 → _mul = 1 (2^31 ≡ 1).
- Inverse cross-check: a = 7, b = 1840700269 → _mul = 1. a = 0x7FFFFFFF, b = 123 → _mul = 0. a = 0, b = 0x12345678 → _mul = 0.
- Busy immunity:
  - start a = 6, b = 7;
  - at E5, pulse opselect with a = 2, b = 2, and change a and b every cycle;
  - → _mul = 42 after E32, no second operation starts, and _rdy stays 1 afterwards.
- Reset mid-operation:
  - start a = 100, b = 200; drive rst_n = 0 at E10;
  - → _rdy = 1 and _mul = 0 after E10, and _mul stays 0 with no late update.
  - A new start at E12 with a = 9, b = 9 → _mul = 81 after E44.
- Random regression: 10k random a, b in [0, p], with opselect held high for back-to-back operations → each _mul matches a·b mod p (canonical) and every operation shows exactly 32 cycles of latency.
